mtm_alu_sequencer: RTL and testbench

- Controller between the ALU deserializer, the ALU core and the result serializer.
- Accepts decoded operand packets through a 1-entry pending buffer and checks opcode and frame error flags.
- For valid packets: launches the ALU, captures result and flags, and hands them to the serializer with a 1-cycle valid pulse.
- For invalid packets: issues an error report instead.
- Paces the next issue so the serializer never receives a new valid while a frame train is still on the line.

---
 rtl/mtm_alu_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_mtm_alu_sequencer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_sequencer.sv
// -----------------------------------------------------------------------------
// mtm_alu_sequencer
//
// Sits between the ALU deserializer, the ALU core and the result serializer.
// Decoded operand packets go into a one-entry pending buffer. Each packet is
// then either launched on the ALU or turned into an error report. The block
// also spaces issues apart so the serializer is never handed a new valid while
// a frame train is still being shifted out.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        deserializer handshake (in_ready = !pend_valid)
//   in_A, in_B, in_op, in_err  packet payload and deserializer error flags
//   alu_A, alu_B, alu_op       registered operands to the ALU core
//   alu_start / alu_done       one-cycle launch pulse / result valid
//   alu_C, alu_flags           ALU result and {carry, overflow, zero, negative}
//   res_valid, res_C,          one-cycle result pulse and captured result
//   res_flags
//   err_valid, err_flags       one-cycle error pulse, {ERR_DATA, ERR_CRC, ERR_OP}
//   busy                       high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module mtm_alu_sequencer #(
    parameter int unsigned TX_CYCLES     = 55,
    parameter int unsigned ERR_TX_CYCLES = 11,
    parameter int unsigned ALU_TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_A,
    input  logic [31:0] in_B,
    input  logic [2:0]  in_op,
    input  logic [2:0]  in_err,

    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [31:0] alu_C,
    input  logic [3:0]  alu_flags,

    output logic        res_valid,
    output logic [31:0] res_C,
    output logic [3:0]  res_flags,

    output logic        err_valid,
    output logic [2:0]  err_flags,

    output logic        busy
);

    // Hold counter only ever holds (cycles - 1), so clog2 of the larger
    // train length is enough; same reasoning for the timeout counter.
    localparam int unsigned HoldMax = (TX_CYCLES > ERR_TX_CYCLES) ? TX_CYCLES : ERR_TX_CYCLES;
    localparam int unsigned HoldW   = (HoldMax > 1) ? $clog2(HoldMax) : 1;
    localparam int unsigned TmoW    = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;

    localparam logic [HoldW-1:0] HoldResp = HoldW'(TX_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldErr  = HoldW'(ERR_TX_CYCLES - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(ALU_TIMEOUT - 1);

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b100;
    localparam logic [2:0] OpSub = 3'b101;

    // Error code used when the ALU never answers.
    localparam logic [2:0] ErrInternal = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StResp,
        StErr,
        StHold
    } state_e;

    state_e            state_q;

    // Pending buffer
    logic              pend_valid_q;
    logic [31:0]       pend_a_q;
    logic [31:0]       pend_b_q;
    logic [2:0]        pend_op_q;
    logic [2:0]        pend_err_q;

    logic [HoldW-1:0]  hold_cnt_q;
    logic [TmoW-1:0]   tmo_cnt_q;

    // Error code staged on entry to StErr, published with the err_valid pulse.
    logic [2:0]        err_code_q;

    logic              accept;
    logic              op_illegal;
    logic              pend_bad;

    assign in_ready = !pend_valid_q;
    assign accept   = in_valid && !pend_valid_q;
    assign busy     = (state_q != StIdle);

    always_comb begin
        op_illegal = 1'b1;
        case (pend_op_q)
            OpAnd, OpOr, OpAdd, OpSub: op_illegal = 1'b0;
            default:                   op_illegal = 1'b1;
        endcase
    end

    assign pend_bad = (pend_err_q != 3'b000) || op_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            pend_a_q     <= '0;
            pend_b_q     <= '0;
            pend_op_q    <= '0;
            pend_err_q   <= '0;
            hold_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            err_code_q   <= '0;
            alu_A        <= '0;
            alu_B        <= '0;
            alu_op       <= '0;
            alu_start    <= 1'b0;
            res_valid    <= 1'b0;
            res_C        <= '0;
            res_flags    <= '0;
            err_valid    <= 1'b0;
            err_flags    <= '0;
        end else begin
            // Pulses default low; each state raises its own for one cycle.
            alu_start <= 1'b0;
            res_valid <= 1'b0;
            err_valid <= 1'b0;

            // Accept and dequeue are exclusive: accept needs pend_valid=0,
            // dequeue needs pend_valid=1, so no same-cycle refill is possible.
            if (accept) begin
                pend_valid_q <= 1'b1;
                pend_a_q     <= in_A;
                pend_b_q     <= in_B;
                pend_op_q    <= in_op;
                pend_err_q   <= in_err;
            end

            unique case (state_q)
                StIdle: begin
                    if (pend_valid_q) begin
                        pend_valid_q <= 1'b0;
                        if (pend_bad) begin
                            err_code_q <= {pend_err_q[2:1], op_illegal};
                            state_q    <= StErr;
                        end else begin
                            alu_A     <= pend_a_q;
                            alu_B     <= pend_b_q;
                            alu_op    <= pend_op_q;
                            alu_start <= 1'b1;
                            tmo_cnt_q <= '0;
                            state_q   <= StExec;
                        end
                    end
                end

                StExec: begin
                    // alu_done is checked first so it wins a tie with the
                    // last timeout cycle.
                    if (alu_done) begin
                        res_C     <= alu_C;
                        res_flags <= alu_flags;
                        state_q   <= StResp;
                    end else if (tmo_cnt_q == TmoLast) begin
                        err_code_q <= ErrInternal;
                        state_q    <= StErr;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end

                StResp: begin
                    res_valid  <= 1'b1;
                    hold_cnt_q <= HoldResp;
                    state_q    <= StHold;
                end

                StErr: begin
                    err_valid  <= 1'b1;
                    err_flags  <= err_code_q;
                    hold_cnt_q <= HoldErr;
                    state_q    <= StHold;
                end

                StHold: begin
                    if (hold_cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_sequencer.sv
// Self-checking bench for mtm_alu_sequencer. A behavioural ALU answers
// alu_start after a programmable delay; expected pulses go into a scoreboard
// when a packet is driven and are popped when the DUT emits them.
module tb_mtm_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_A;
    logic [31:0] in_B;
    logic [2:0]  in_op;
    logic [2:0]  in_err;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [31:0] alu_C;
    logic [3:0]  alu_flags;
    logic        res_valid;
    logic [31:0] res_C;
    logic [3:0]  res_flags;
    logic        err_valid;
    logic [2:0]  err_flags;
    logic        busy;

    mtm_alu_sequencer #(
        .TX_CYCLES     (55),
        .ERR_TX_CYCLES (11),
        .ALU_TIMEOUT   (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_op     (in_op),
        .in_err    (in_err),
        .alu_A     (alu_A),
        .alu_B     (alu_B),
        .alu_op    (alu_op),
        .alu_start (alu_start),
        .alu_done  (alu_done),
        .alu_C     (alu_C),
        .alu_flags (alu_flags),
        .res_valid (res_valid),
        .res_C     (res_C),
        .res_flags (res_flags),
        .err_valid (err_valid),
        .err_flags (err_flags),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [31:0] c;
        logic [3:0]  flags;
        logic [2:0]  ef;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } launch_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  err;
        logic [7:0]  delay;
        logic        launch;
        logic        exp_err;
        logic [31:0] exp_c;
        logic [3:0]  exp_flags;
        logic [2:0]  exp_ef;
    } vec_t;

    exp_t    sb[$];
    launch_t launch_q[$];
    vec_t    vecs[$];
    int      start_gaps[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_start_cyc = -1000;
    int last_res_cyc   = -1000;
    int last_err_cyc   = -1000;
    int acc_cyc        = 0;
    int idle_cyc       = 0;
    int res_count      = 0;
    int err_count      = 0;

    // Behavioural ALU state
    bit alu_enable = 1'b1;
    int alu_delay  = 2;
    int alu_cd     = 0;
    int stray_at   = -1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Returns {carry, overflow, zero, negative, result}.
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        logic [32:0] w;
        logic [31:0] r;
        logic        cy;
        logic        ov;
        r  = '0;
        cy = 1'b0;
        ov = 1'b0;
        w  = '0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b100: begin
                w  = {1'b0, a} + {1'b0, b};
                r  = w[31:0];
                cy = w[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b101: begin
                r  = a - b;
                cy = (a < b);
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: r = '0;
        endcase
        return {cy, ov, (r == 32'd0), r[31], r};
    endfunction

    function automatic vec_t mkv(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [2:0] err,
                                 input logic [7:0] delay, input logic launch,
                                 input logic exp_err, input logic [31:0] exp_c,
                                 input logic [3:0] exp_flags, input logic [2:0] exp_ef);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.err = err; v.delay = delay; v.launch = launch;
        v.exp_err = exp_err; v.exp_c = exp_c; v.exp_flags = exp_flags; v.exp_ef = exp_ef;
        return v;
    endfunction

    task automatic push_res(input logic [31:0] c, input logic [3:0] f);
        exp_t e;
        e.is_err = 1'b0; e.c = c; e.flags = f; e.ef = '0;
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [2:0] ef);
        exp_t e;
        e.is_err = 1'b1; e.c = '0; e.flags = '0; e.ef = ef;
        sb.push_back(e);
    endtask

    task automatic push_launch(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op);
        launch_t l;
        l.a = a; l.b = b; l.op = op;
        launch_q.push_back(l);
    endtask

    // One clock: drive the ALU model for the next edge, then monitor outputs.
    task automatic step();
        logic [35:0] r;
        launch_t     l;
        exp_t        e;
        @(posedge clk);
        #1;
        cyc++;

        alu_done = 1'b0;
        if (alu_cd > 0) begin
            alu_cd--;
            if (alu_cd == 0) begin
                r         = alu_fn(alu_A, alu_B, alu_op);
                alu_C     = r[31:0];
                alu_flags = r[35:32];
                alu_done  = 1'b1;
            end
        end
        if (cyc == stray_at) alu_done = 1'b1;

        if (alu_start) begin
            start_gaps.push_back(cyc - last_res_cyc);
            last_start_cyc = cyc;
            if (launch_q.size() == 0) begin
                chk("unexpected alu_start", longint'(alu_start), 0);
            end else begin
                l = launch_q.pop_front();
                chk("alu_A", longint'(alu_A), longint'(l.a));
                chk("alu_B", longint'(alu_B), longint'(l.b));
                chk("alu_op", longint'(alu_op), longint'(l.op));
            end
            if (alu_enable) alu_cd = alu_delay;
        end

        if (res_valid) begin
            res_count++;
            last_res_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected res_valid", longint'(res_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("res_valid kind", longint'(res_valid), longint'(!e.is_err));
                chk("res_C", longint'(res_C), longint'(e.c));
                chk("res_flags", longint'(res_flags), longint'(e.flags));
            end
        end

        if (err_valid) begin
            err_count++;
            last_err_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected err_valid", longint'(err_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("err_valid kind", longint'(err_valid), longint'(e.is_err));
                chk("err_flags", longint'(err_flags), longint'(e.ef));
            end
        end
    endtask

    // Hold in_valid until the DUT takes the packet; acc_cyc marks the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [2:0] err);
        int n;
        in_valid = 1'b1;
        in_A     = a;
        in_B     = b;
        in_op    = op;
        in_err   = err;
        n = 0;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        if (!in_ready) begin
            chk("send accept timeout", longint'(in_ready), 1);
        end else begin
            step();
            acc_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            step();
            if (!busy && in_ready && sb.size() == 0 && launch_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        idle_cyc = cyc;
        if (!ok) chk({tag, " idle timeout"}, 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " alu_A"}, longint'(alu_A), 0);
        chk({tag, " alu_B"}, longint'(alu_B), 0);
        chk({tag, " alu_op"}, longint'(alu_op), 0);
        chk({tag, " alu_start"}, longint'(alu_start), 0);
        chk({tag, " res_valid"}, longint'(res_valid), 0);
        chk({tag, " res_C"}, longint'(res_C), 0);
        chk({tag, " res_flags"}, longint'(res_flags), 0);
        chk({tag, " err_valid"}, longint'(err_valid), 0);
        chk({tag, " err_flags"}, longint'(err_flags), 0);
        chk({tag, " busy"}, longint'(busy), 0);
        chk({tag, " in_ready"}, longint'(in_ready), 1);
    endtask

    initial begin
        int rc;
        int ec;
        bit seen;

        // Vector table: A, B, op, err, ALU delay, launches?, expect err?, C, flags, err_flags
        vecs.push_back(mkv(32'h00000005, 32'h00000003, 3'b100, 3'b000, 8'd2,  1, 0, 32'h00000008, 4'b0000, 3'b000));
        vecs.push_back(mkv(32'h00000001, 32'h00000002, 3'b010, 3'b000, 8'd2,  0, 1, 32'h0,        4'b0000, 3'b001));
        vecs.push_back(mkv(32'h00000001, 32'h00000002, 3'b000, 3'b110, 8'd2,  0, 1, 32'h0,        4'b0000, 3'b110));
        vecs.push_back(mkv(32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 3'b000, 8'd3,  1, 0, 32'hF000F000, 4'b0001, 3'b000));
        vecs.push_back(mkv(32'h0000000F, 32'h000000F0, 3'b001, 3'b000, 8'd1,  1, 0, 32'h000000FF, 4'b0000, 3'b000));
        vecs.push_back(mkv(32'hFFFFFFFF, 32'h00000001, 3'b100, 3'b000, 8'd2,  1, 0, 32'h00000000, 4'b1010, 3'b000));
        vecs.push_back(mkv(32'h7FFFFFFF, 32'h00000001, 3'b100, 3'b000, 8'd2,  1, 0, 32'h80000000, 4'b0101, 3'b000));
        vecs.push_back(mkv(32'h00000003, 32'h00000005, 3'b101, 3'b000, 8'd2,  1, 0, 32'hFFFFFFFE, 4'b1001, 3'b000));
        vecs.push_back(mkv(32'h00000007, 32'h00000007, 3'b101, 3'b000, 8'd2,  1, 0, 32'h00000000, 4'b0010, 3'b000));
        vecs.push_back(mkv(32'h00000001, 32'h00000001, 3'b111, 3'b000, 8'd2,  0, 1, 32'h0,        4'b0000, 3'b001));
        vecs.push_back(mkv(32'h00000001, 32'h00000001, 3'b011, 3'b100, 8'd2,  0, 1, 32'h0,        4'b0000, 3'b101));
        vecs.push_back(mkv(32'h00000001, 32'h00000001, 3'b110, 3'b010, 8'd2,  0, 1, 32'h0,        4'b0000, 3'b011));
        // done on the last timeout cycle wins; one cycle later it is too late
        vecs.push_back(mkv(32'h0000000A, 32'h00000004, 3'b101, 3'b000, 8'd14, 1, 0, 32'h00000006, 4'b0000, 3'b000));
        vecs.push_back(mkv(32'h0000000A, 32'h00000004, 3'b101, 3'b000, 8'd15, 1, 1, 32'h0,        4'b0000, 3'b111));

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_A      = '0;
        in_B      = '0;
        in_op     = '0;
        in_err    = '0;
        alu_done  = 1'b0;
        alu_C     = '0;
        alu_flags = '0;

        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Stray alu_done while idle must do nothing.
        stray_at = cyc + 2;
        repeat (6) step();
        chk("stray done idle res", res_count, 0);
        chk("stray done idle busy", longint'(busy), 0);

        // First packet: launch latency and busy span after res_valid.
        alu_delay = 2;
        push_launch(32'h5, 32'h3, 3'b100);
        push_res(32'h8, 4'b0000);
        send(32'h5, 32'h3, 3'b100, 3'b000);
        wait_idle("first");
        chk("start latency", last_start_cyc - acc_cyc, 1);
        chk("busy span after res", idle_cyc - last_res_cyc, 55);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            alu_delay = int'(vecs[i].delay);
            if (vecs[i].launch) push_launch(vecs[i].a, vecs[i].b, vecs[i].op);
            if (vecs[i].exp_err) push_err(vecs[i].exp_ef);
            else push_res(vecs[i].exp_c, vecs[i].exp_flags);
            send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].err);
            wait_idle($sformatf("vec%0d", i));
        end

        // Error report followed by a queued legal packet: 12-cycle spacing.
        alu_delay = 2;
        push_err(3'b001);
        send(32'h1, 32'h2, 3'b010, 3'b000);
        push_launch(32'h5, 32'h3, 3'b100);
        push_res(32'h8, 4'b0000);
        send(32'h5, 32'h3, 3'b100, 3'b000);
        wait_idle("err gap");
        chk("err to next start", last_start_cyc - last_err_cyc, 12);

        // Back-to-back: second accepted during EXEC, third blocked.
        start_gaps.delete();
        push_launch(32'h10, 32'h20, 3'b100);
        push_res(32'h30, 4'b0000);
        send(32'h10, 32'h20, 3'b100, 3'b000);
        push_launch(32'hFF, 32'h0F, 3'b000);
        push_res(32'h0F, 4'b0000);
        send(32'hFF, 32'h0F, 3'b000, 3'b000);
        chk("second accepted in EXEC busy", longint'(busy), 1);
        chk("third blocked in_ready", longint'(in_ready), 0);
        push_launch(32'h100, 32'h001, 3'b001);
        push_res(32'h101, 4'b0000);
        send(32'h100, 32'h001, 3'b001, 3'b000);
        wait_idle("b2b");
        chk("b2b start count", start_gaps.size(), 3);
        if (start_gaps.size() >= 3) begin
            chk("b2b gap 1", start_gaps[1], 56);
            chk("b2b gap 2", start_gaps[2], 56);
        end

        // ALU timeout, then a late alu_done in HOLD.
        alu_enable = 1'b0;
        rc = res_count;
        ec = err_count;
        push_launch(32'h9, 32'h9, 3'b000);
        push_err(3'b111);
        send(32'h9, 32'h9, 3'b000, 3'b000);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step();
            if (err_count != ec) begin
                seen = 1'b1;
                break;
            end
        end
        chk("timeout err seen", longint'(seen), 1);
        chk("timeout latency", last_err_cyc - last_start_cyc, 16);
        stray_at = cyc + 3;
        wait_idle("timeout");
        chk("late done no res", res_count, rc);
        alu_enable = 1'b1;

        // Reset during EXEC with a second packet pending.
        alu_delay = 10;
        push_launch(32'h1, 32'h2, 3'b100);
        push_res(32'h3, 4'b0000);
        send(32'h1, 32'h2, 3'b100, 3'b000);
        push_launch(32'h4, 32'h4, 3'b100);
        push_res(32'h8, 4'b0000);
        send(32'h4, 32'h4, 3'b100, 3'b000);
        step();
        step();
        rst = 1'b1;
        step();
        check_reset_outputs("mid reset");
        rst = 1'b0;
        sb.delete();
        launch_q.delete();
        rc = res_count;
        repeat (20) step();
        chk("no res after reset", res_count, rc);
        chk("idle after reset", longint'(busy), 0);

        alu_delay = 2;
        push_launch(32'h12345678, 32'h11111111, 3'b101);
        push_res(32'h01234567, 4'b0000);
        send(32'h12345678, 32'h11111111, 3'b101, 3'b000);
        wait_idle("post reset");
        chk("post reset start latency", last_start_cyc - acc_cyc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
